rx_deframer: RTL and testbench

Receive-side PHY deframer, the counterpart to the transmit bit path (inFIFO to MSK modulator). It sits between cdr (o_data/o_flag) and outFIFO (inData/inWriteEnable). It consumes the recovered serial bit stream, locks on the 802.15.4 preamble and SFD, and extracts the PHR length. It then forwards exactly length×8 payload bits to outFIFO and flags frame start, end and errors.

---
 rtl/rx_deframer.sv | 180 ++++++++++++++++++
 tb/tb_rx_deframer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// Receive deframer: hunts for an 802.15.4 preamble and SFD in the recovered bit
// stream, decodes the PHR length and forwards length*8 payload bits to the FIFO.
module rx_deframer #(
  parameter int PREAMBLE_MIN = 24,
  parameter int SFD_TIMEOUT  = 16,
  parameter int MAX_LEN      = 127
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inData,
  input  logic       inFlag,
  input  logic       inFull,
  output logic       outData,
  output logic       outWriteEnable,
  output logic [6:0] outLength,
  output logic       outFrameStart,
  output logic       outFrameDone,
  output logic       outSyncError,
  output logic       outOverflow,
  output logic       outBusy
);

  localparam int         ZC_W = $clog2(PREAMBLE_MIN + 1);
  localparam int         TC_W = $clog2(SFD_TIMEOUT + 1);
  localparam logic [7:0] SFD  = 8'hA7;

  typedef enum logic [1:0] {HUNT, SFD_SEARCH, PHR, PAYLOAD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic [ZC_W-1:0] zc_q, zc_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic [2:0]      bc_q, bc_d;
  logic [9:0]      pc_q, pc_d;
  logic            data_q, data_d;
  logic            we_q, we_d;
  logic [6:0]      len_q, len_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            serr_q, serr_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

  logic [7:0] sh_next;
  logic [6:0] phr_len;

  // The octet as it will look once the current bit is shifted in (LSB first).
  assign sh_next = {inData, sh_q[7:1]};
  assign phr_len = sh_next[6:0];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can leave
    // it unassigned; a missing default here is what infers a latch.
    state_d = state_q;
    sh_d    = sh_q;
    zc_d    = zc_q;
    tc_d    = tc_q;
    bc_d    = bc_q;
    pc_d    = pc_q;
    data_d  = data_q;
    len_d   = len_q;
    we_d    = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    serr_d  = 1'b0;
    ovf_d   = 1'b0;

    if (inFlag) begin
      sh_d = sh_next;
      unique case (state_q)
        HUNT: begin
          if (inData) begin
            zc_d = '0;
          end else if (zc_q == ZC_W'(PREAMBLE_MIN - 1)) begin
            zc_d    = '0;
            tc_d    = '0;
            state_d = SFD_SEARCH;
          end else begin
            zc_d = zc_q + ZC_W'(1);
          end
        end

        SFD_SEARCH: begin
          // Extra preamble zeros keep the search window open indefinitely.
          tc_d = (!inData && sh_q[7:1] == 7'd0) ? '0 : tc_q + TC_W'(1);
          if (sh_next == SFD) begin
            bc_d    = '0;
            state_d = PHR;
          end else if (tc_d == TC_W'(SFD_TIMEOUT)) begin
            serr_d  = 1'b1;
            zc_d    = '0;
            state_d = HUNT;
          end
        end

        PHR: begin
          bc_d = bc_q + 3'd1;
          if (bc_q == 3'd7) begin
            // Bit 7 of the PHR is reserved and takes no part in the length.
            if (phr_len == 7'd0 || {1'b0, phr_len} > 8'(MAX_LEN)) begin
              serr_d  = 1'b1;
              zc_d    = '0;
              state_d = HUNT;
            end else begin
              len_d   = phr_len;
              start_d = 1'b1;
              pc_d    = {phr_len, 3'b000};
              state_d = PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (inFull) begin
            ovf_d   = 1'b1;
            zc_d    = '0;
            state_d = HUNT;
          end else begin
            data_d = inData;
            we_d   = 1'b1;
            pc_d   = pc_q - 10'd1;
            if (pc_q == 10'd1) begin
              done_d  = 1'b1;
              zc_d    = '0;
              state_d = HUNT;
            end
          end
        end
      endcase
    end

    busy_d = (state_d == PHR) || (state_d == PAYLOAD);
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state_q <= HUNT;
      sh_q    <= '0;
      zc_q    <= '0;
      tc_q    <= '0;
      bc_q    <= '0;
      pc_q    <= '0;
      data_q  <= 1'b0;
      we_q    <= 1'b0;
      len_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of
      // the others; blocking here would create order-dependent behaviour.
      state_q <= state_d;
      sh_q    <= sh_d;
      zc_q    <= zc_d;
      tc_q    <= tc_d;
      bc_q    <= bc_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      we_q    <= we_d;
      len_q   <= len_d;
      start_q <= start_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign outData        = data_q;
  assign outWriteEnable = we_q;
  assign outLength      = len_q;
  assign outFrameStart  = start_q;
  assign outFrameDone   = done_q;
  assign outSyncError   = serr_q;
  assign outOverflow    = ovf_q;
  assign outBusy        = busy_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: two instances (MAX_LEN 127 and 10) share one input
// stream; every cycle is compared against a bit-level behavioural model.
module tb_rx_deframer;

  localparam int PRE    = 24;
  localparam int TO     = 16;
  localparam int MAXL_A = 127;
  localparam int MAXL_B = 10;

  localparam int HUNTING = 0;
  localparam int SEEKING = 1;
  localparam int HEADER  = 2;
  localparam int BODY    = 3;

  logic inClock = 1'b0;
  logic inReset = 1'b1;
  logic inData  = 1'b0;
  logic inFlag  = 1'b0;
  logic inFull  = 1'b0;

  logic       a_data, a_we, a_start, a_done, a_serr, a_ovf, a_busy;
  logic [6:0] a_len;
  logic       b_data, b_we, b_start, b_done, b_serr, b_ovf, b_busy;
  logic [6:0] b_len;

  rx_deframer #(.PREAMBLE_MIN(PRE), .SFD_TIMEOUT(TO), .MAX_LEN(MAXL_A)) dut_a (
    .inClock(inClock), .inReset(inReset), .inData(inData), .inFlag(inFlag),
    .inFull(inFull), .outData(a_data), .outWriteEnable(a_we), .outLength(a_len),
    .outFrameStart(a_start), .outFrameDone(a_done), .outSyncError(a_serr),
    .outOverflow(a_ovf), .outBusy(a_busy)
  );

  rx_deframer #(.PREAMBLE_MIN(PRE), .SFD_TIMEOUT(TO), .MAX_LEN(MAXL_B)) dut_b (
    .inClock(inClock), .inReset(inReset), .inData(inData), .inFlag(inFlag),
    .inFull(inFull), .outData(b_data), .outWriteEnable(b_we), .outLength(b_len),
    .outFrameStart(b_start), .outFrameDone(b_done), .outSyncError(b_serr),
    .outOverflow(b_ovf), .outBusy(b_busy)
  );

  always #5 inClock = ~inClock;

  typedef struct packed {
    logic       data;
    logic       we;
    logic [6:0] len;
    logic       start;
    logic       done;
    logic       serr;
    logic       ovf;
    logic       busy;
  } obs_t;

  typedef struct {
    int   phase;
    int   zeros;
    int   misses;
    int   last8;
    int   hdr;
    int   nhdr;
    int   remaining;
    int   len;
    logic data;
  } model_t;

  typedef struct {
    string       name;
    int          pre;
    logic [15:0] sync;
    int          sync_bits;
    bit          has_phr;
    logic [7:0]  phr;
    int          nbytes;
    logic [31:0] pay4;
    int          full_at;
    int          gap;
    int          e_start, e_we, e_done, e_serr, e_ovf, e_len;
    int          e_start_b, e_serr_b;
  } row_t;

  obs_t act_a, act_b;
  assign act_a = {a_data, a_we, a_len, a_start, a_done, a_serr, a_ovf, a_busy};
  assign act_b = {b_data, b_we, b_len, b_start, b_done, b_serr, b_ovf, b_busy};

  model_t ma, mb;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     gap_mode = -1;
  int     cnt_start_a, cnt_we_a, cnt_done_a, cnt_serr_a, cnt_ovf_a;
  int     cnt_start_b, cnt_serr_b;
  row_t   rows[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset(output model_t m);
    m = '{HUNTING, 0, 0, 0, 0, 0, 0, 0, 1'b0};
  endtask

  function automatic obs_t expect_idle(input model_t m);
    obs_t o;
    o      = '0;
    o.data = m.data;
    o.len  = 7'(m.len);
    o.busy = (m.phase == HEADER) || (m.phase == BODY);
    return o;
  endfunction

  // One received bit, straight from the frame rules: zero-run preamble,
  // SFD seen in the last eight bits, length from the header octet.
  task automatic model_step(inout model_t m, input logic b, input logic full,
                            input int max_len, output obs_t o);
    int   prev;
    int   l;
    logic we, start, done, serr, ovf;
    we = 0; start = 0; done = 0; serr = 0; ovf = 0;
    prev    = m.last8;
    m.last8 = (prev >> 1) | (int'(b) << 7);
    case (m.phase)
      HUNTING: begin
        m.zeros = b ? 0 : m.zeros + 1;
        if (m.zeros == PRE) begin
          m.phase = SEEKING; m.misses = 0; m.zeros = 0;
        end
      end
      SEEKING: begin
        if (!b && (prev >> 1) == 0) m.misses = 0;
        else m.misses++;
        if (m.last8 == 'hA7) begin
          m.phase = HEADER; m.hdr = 0; m.nhdr = 0;
        end else if (m.misses == TO) begin
          serr = 1; m.phase = HUNTING; m.zeros = 0;
        end
      end
      HEADER: begin
        m.hdr += int'(b) << m.nhdr;
        m.nhdr++;
        if (m.nhdr == 8) begin
          l = m.hdr % 128;
          if (l == 0 || l > max_len) begin
            serr = 1; m.phase = HUNTING; m.zeros = 0;
          end else begin
            start = 1; m.len = l; m.remaining = l * 8; m.phase = BODY;
          end
        end
      end
      default: begin
        if (full) begin
          ovf = 1; m.phase = HUNTING; m.zeros = 0;
        end else begin
          we = 1; m.data = b; m.remaining--;
          if (m.remaining == 0) begin
            done = 1; m.phase = HUNTING; m.zeros = 0;
          end
        end
      end
    endcase
    o       = expect_idle(m);
    o.we    = we;
    o.start = start;
    o.done  = done;
    o.serr  = serr;
    o.ovf   = ovf;
  endtask

  task automatic cycle(input logic flag, input logic b, input logic full);
    obs_t ea, eb;
    inFlag = flag;
    inData = b;
    inFull = full;
    if (flag) begin
      model_step(ma, b, full, MAXL_A, ea);
      model_step(mb, b, full, MAXL_B, eb);
    end else begin
      ea = expect_idle(ma);
      eb = expect_idle(mb);
    end
    @(posedge inClock);
    @(negedge inClock);
    check("dut_a outputs", 32'(act_a), 32'(ea));
    check("dut_b outputs", 32'(act_b), 32'(eb));
    cnt_start_a += int'(a_start);
    cnt_we_a    += int'(a_we);
    cnt_done_a  += int'(a_done);
    cnt_serr_a  += int'(a_serr);
    cnt_ovf_a   += int'(a_ovf);
    cnt_start_b += int'(b_start);
    cnt_serr_b  += int'(b_serr);
  endtask

  task automatic send_bit(input logic b, input logic full);
    int g;
    cycle(1'b1, b, full);
    g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
    repeat (g) cycle(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic clear_counts();
    cnt_start_a = 0; cnt_we_a = 0; cnt_done_a = 0; cnt_serr_a = 0; cnt_ovf_a = 0;
    cnt_start_b = 0; cnt_serr_b = 0;
  endtask

  task automatic run_row(input row_t r);
    logic [7:0] byt;
    logic       full;
    clear_counts();
    gap_mode = r.gap;
    repeat (r.pre) send_bit(1'b0, 1'b0);
    for (int i = 0; i < r.sync_bits; i++) send_bit(r.sync[i], 1'b0);
    if (r.has_phr) send_byte(r.phr);
    for (int i = 0; i < r.nbytes * 8; i++) begin
      byt  = r.pay4[8 * ((i / 8) % 4) +: 8];
      full = (i == r.full_at);
      send_bit(byt[i % 8], full);
      if (full) break;
    end
    gap_mode = -1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check({r.name, " starts"},   32'(cnt_start_a), 32'(r.e_start));
    check({r.name, " writes"},   32'(cnt_we_a),    32'(r.e_we));
    check({r.name, " dones"},    32'(cnt_done_a),  32'(r.e_done));
    check({r.name, " syncerr"},  32'(cnt_serr_a),  32'(r.e_serr));
    check({r.name, " overflow"}, 32'(cnt_ovf_a),   32'(r.e_ovf));
    check({r.name, " length"},   32'(a_len),       32'(r.e_len));
    check({r.name, " busy"},     32'(a_busy),      32'd0);
    check({r.name, " starts_b"}, 32'(cnt_start_b), 32'(r.e_start_b));
    check({r.name, " syncerr_b"},32'(cnt_serr_b),  32'(r.e_serr_b));
  endtask

  initial begin
    logic [7:0] sfd, phr;
    int         pre, l, nbits;

    rows[0]  = '{"clean_3",     32, 16'h00A7, 8,  1'b1, 8'h03, 3,   32'h00FF3AC5, -1, 3,  1, 24,   1, 0, 0, 3,   1, 0};
    rows[1]  = '{"short_pre",   16, 16'h00A7, 8,  1'b1, 8'h02, 2,   32'h00005A3C, -1, -1, 0, 0,    0, 0, 0, 3,   0, 0};
    rows[2]  = '{"sfd_timeout", 32, 16'h5555, 16, 1'b0, 8'h00, 0,   32'h00000000, -1, -1, 0, 0,    0, 1, 0, 3,   0, 1};
    rows[3]  = '{"clean_2",     32, 16'h00A7, 8,  1'b1, 8'h02, 2,   32'h0000817E, -1, -1, 1, 16,   1, 0, 0, 2,   1, 0};
    rows[4]  = '{"phr_00",      32, 16'h00A7, 8,  1'b1, 8'h00, 0,   32'h00000000, -1, -1, 0, 0,    0, 1, 0, 2,   0, 1};
    rows[5]  = '{"phr_80",      32, 16'h00A7, 8,  1'b1, 8'h80, 0,   32'h00000000, -1, -1, 0, 0,    0, 1, 0, 2,   0, 1};
    rows[6]  = '{"phr_0b",      32, 16'h00A7, 8,  1'b1, 8'h0B, 11,  32'h5A3CC3A5, -1, -1, 1, 88,   1, 0, 0, 11,  0, 1};
    rows[7]  = '{"overflow",    32, 16'h00A7, 8,  1'b1, 8'h02, 2,   32'h0000F096, 4,  -1, 1, 4,    0, 0, 1, 2,   1, 0};
    rows[8]  = '{"clean_1",     32, 16'h00A7, 8,  1'b1, 8'h01, 1,   32'h0000003C, -1, -1, 1, 8,    1, 0, 0, 1,   1, 0};
    rows[9]  = '{"phr_ff",      32, 16'h00A7, 8,  1'b1, 8'hFF, 127, 32'h5A3CC3A5, -1, -1, 1, 1016, 1, 0, 0, 127, 0, 1};
    rows[10] = '{"phr_8a",      32, 16'h00A7, 8,  1'b1, 8'h8A, 10,  32'h5A3CC3A5, -1, -1, 1, 80,   1, 0, 0, 10,  1, 0};

    model_reset(ma);
    model_reset(mb);
    clear_counts();
    @(negedge inClock);
    check("reset state a", 32'(act_a), 32'd0);
    check("reset state b", 32'(act_b), 32'd0);
    @(negedge inClock);
    inReset = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 11; r++) run_row(rows[r]);

    // Reset lands in the middle of the 10th payload bit of a 4-octet frame.
    clear_counts();
    gap_mode = -1;
    repeat (32) send_bit(1'b0, 1'b0);
    send_byte(8'hA7);
    send_byte(8'h04);
    repeat (9) send_bit(1'b1, 1'b0);
    check("busy before reset", 32'(a_busy), 32'd1);
    check("len before reset", 32'(a_len), 32'd4);
    inFlag = 1'b1;
    inData = 1'b0;
    inFull = 1'b0;
    #2 inReset = 1'b1;
    #1;
    check("async reset a", 32'(act_a), 32'd0);
    check("async reset b", 32'(act_b), 32'd0);
    @(posedge inClock);
    @(negedge inClock);
    inReset = 1'b0;
    model_reset(ma);
    model_reset(mb);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    check("no done after reset", 32'(cnt_done_a), 32'd0);
    run_row(rows[0]);

    // Random frames, scored only by the per-cycle model comparison.
    for (int f = 0; f < 25; f++) begin
      gap_mode = -1;
      pre = int'($urandom_range(12, 34));
      repeat (pre) send_bit(1'b0, 1'b0);
      sfd = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hA7;
      send_byte(sfd);
      l   = int'($urandom_range(0, 14));
      phr = {1'($urandom), 7'(l)};
      send_byte(phr);
      nbits = (l == 0) ? 8 : l * 8;
      for (int i = 0; i < nbits; i++)
        send_bit(1'($urandom), $urandom_range(0, 149) == 0);
      repeat (int'($urandom_range(0, 6))) send_bit(1'($urandom), 1'b0);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
